// File: rtl/keypad_operand_entry_if.sv
// Operand hand-off from keypad entry to the arithmetic/display stage.
// The master drives operands/op_code/out_valid; the slave returns out_ready.
interface keypad_operand_entry_if #(
    parameter int unsigned OP_W = 10
);
    logic [OP_W-1:0] operand_a;
    logic [OP_W-1:0] operand_b;
    logic [1:0]      op_code;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output operand_a,
        output operand_b,
        output op_code,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  operand_a,
        input  operand_b,
        input  op_code,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/keypad_operand_entry.sv
// Debounces scanned keypad codes into one-shot key events and assembles
// two decimal operands plus an operator for a valid/ready consumer.
module keypad_operand_entry #(
    parameter int unsigned PRESS_CYCLES   = 1024,
    parameter int unsigned RELEASE_CYCLES = 2_500_000,
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned OP_W           = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    sample,
    keypad_operand_entry_if.master        bus,
    output logic                          key_valid,
    output logic [3:0]                    key_code,
    output logic [1:0]                    entry_state
);

    localparam int unsigned PW = (PRESS_CYCLES > 2) ? $clog2(PRESS_CYCLES) : 1;
    localparam int unsigned RW = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
    localparam int unsigned DW = $clog2(DIGITS + 1);

    // Press fires at the end of the cycle in which the counter holds PRESS_CYCLES-2,
    // giving key_valid exactly PRESS_CYCLES cycles after the first stable sample.
    localparam logic [PW-1:0] PRESS_LAST = PW'(PRESS_CYCLES - 2);
    localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_MAX  = DW'(DIGITS);

    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {DetIdle, DetPress, DetHeld} det_e;
    typedef enum logic [1:0] {
        EntryA    = 2'b00,
        EntryB    = 2'b01,
        EntryDone = 2'b10
    } entry_e;

    // Key detector state
    det_e          det_q, det_d;
    logic [3:0]    cand_q, cand_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rel_q, rel_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_q       <= DetIdle;
            cand_q      <= KEY_NONE;
            cnt_q       <= '0;
            rel_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_NONE;
        end else begin
            det_q       <= det_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    always_comb begin
        det_d       = det_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        case (det_q)
            DetIdle: begin
                if (sample != KEY_NONE) begin
                    cand_d = sample;
                    cnt_d  = '0;
                    det_d  = DetPress;
                end
            end
            DetPress: begin
                if (sample == KEY_NONE) begin
                    cnt_d = '0;
                    det_d = DetIdle;
                end else if (sample != cand_q) begin
                    cand_d = sample;
                    cnt_d  = '0;
                end else if (cnt_q == PRESS_LAST) begin
                    key_valid_d = 1'b1;
                    key_code_d  = cand_q;
                    cnt_d       = '0;
                    rel_d       = '0;
                    det_d       = DetHeld;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DetHeld: begin
                // Scan gaps look like F; only an unbroken F run longer than a scan releases.
                if (sample != KEY_NONE) begin
                    rel_d = '0;
                end else if (rel_q == REL_LAST) begin
                    rel_d = '0;
                    det_d = DetIdle;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: det_d = DetIdle;
        endcase
    end

    // Operand entry state
    entry_e          entry_q, entry_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   cnt_a_q, cnt_a_d;
    logic [DW-1:0]   cnt_b_q, cnt_b_d;

    logic            is_digit;
    logic            is_op;
    logic [1:0]      op_sel;
    logic [OP_W-1:0] digit;
    logic [OP_W-1:0] a_next;
    logic [OP_W-1:0] b_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= EntryA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            entry_q <= entry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    always_comb begin
        is_digit = (key_code_q <= 4'd9);
        is_op    = (key_code_q == 4'hA) || (key_code_q == 4'hB) || (key_code_q == 4'hC);
        // A/B/C -> 00/01/10: low two bits plus 2, modulo 4
        op_sel   = key_code_q[1:0] + 2'b10;
        digit    = OP_W'(key_code_q);
        a_next   = (a_q << 3) + (a_q << 1) + digit;
        b_next   = (b_q << 3) + (b_q << 1) + digit;

        entry_d = entry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;

        if ((entry_q == EntryDone && bus.out_ready) ||
            (key_valid_q && key_code_q == KEY_CLEAR)) begin
            entry_d = EntryA;
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'b00;
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else if (key_valid_q) begin
            case (entry_q)
                EntryA: begin
                    if (is_digit && cnt_a_q < DIGIT_MAX) begin
                        a_d     = a_next;
                        cnt_a_d = cnt_a_q + 1'b1;
                    end else if (is_op && cnt_a_q != '0) begin
                        op_d    = op_sel;
                        cnt_b_d = '0;
                        entry_d = EntryB;
                    end
                end
                EntryB: begin
                    if (is_digit && cnt_b_q < DIGIT_MAX) begin
                        b_d     = b_next;
                        cnt_b_d = cnt_b_q + 1'b1;
                    end else if (is_op) begin
                        op_d = op_sel;
                    end else if (key_code_q == KEY_ENTER && cnt_b_q != '0) begin
                        entry_d = EntryDone;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.operand_a = a_q;
    assign bus.operand_b = b_q;
    assign bus.op_code   = op_q;
    assign bus.out_valid = (entry_q == EntryDone);
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign entry_state   = entry_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry with short press/release windows.
module tb_keypad_operand_entry;

    localparam int unsigned OP_W = 10;
    localparam logic [3:0]  KNONE = 4'hF;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sample;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] entry_state;

    keypad_operand_entry_if #(.OP_W(OP_W)) bus_if ();

    keypad_operand_entry #(
        .PRESS_CYCLES   (4),
        .RELEASE_CYCLES (16),
        .DIGITS         (3),
        .OP_W           (OP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .bus         (bus_if),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .entry_state (entry_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [1:0]      op;
    } txn_t;

    logic [3:0] exp_keys[$];
    txn_t       exp_txn[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold a code on sample for n clock edges.
    task automatic hold(input logic [3:0] code, input int n);
        sample = code;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        exp_keys.push_back(code);
        hold(code, 6);
        hold(KNONE, 20);
    endtask

    task automatic check_out(input string tag, input int a, input int b, input int op,
                             input int st, input int v);
        check({tag, "_a"},     int'(bus_if.operand_a), a);
        check({tag, "_b"},     int'(bus_if.operand_b), b);
        check({tag, "_op"},    int'(bus_if.op_code), op);
        check({tag, "_state"}, int'(entry_state), st);
        check({tag, "_valid"}, int'(bus_if.out_valid), v);
    endtask

    logic [3:0] mon_key;
    txn_t       mon_txn;

    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin
                if (exp_keys.size() == 0) begin
                    check("key_spurious", int'(key_valid), 0);
                end else begin
                    mon_key = exp_keys.pop_front();
                    check("key_code", int'(key_code), int'(mon_key));
                end
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_txn.size() == 0) begin
                    check("txn_spurious", int'(bus_if.out_valid), 0);
                end else begin
                    mon_txn = exp_txn.pop_front();
                    check("txn_a",  int'(bus_if.operand_a), int'(mon_txn.a));
                    check("txn_b",  int'(bus_if.operand_b), int'(mon_txn.b));
                    check("txn_op", int'(bus_if.op_code), int'(mon_txn.op));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        sample           = KNONE;
        bus_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_code",  int'(key_code), 15);
        check_out("rst", 0, 0, 0, 0, 0);

        // 123 A 45 E
        press(4'd1); press(4'd2); press(4'd3);
        check_out("a123", 123, 0, 0, 0, 0);
        press(4'hA); press(4'd4); press(4'd5);
        check_out("b45", 123, 45, 0, 1, 0);
        exp_txn.push_back('{a: 10'd123, b: 10'd45, op: 2'b00});
        press(4'hE);
        check_out("done", 123, 45, 0, 2, 1);
        press(4'd7);
        check_out("done_frozen", 123, 45, 0, 2, 1);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check_out("xfer", 0, 0, 0, 0, 0);

        // Scan pattern must yield a single 7
        exp_keys.push_back(4'd7);
        repeat (5) begin
            hold(4'd7, 4);
            hold(KNONE, 12);
        end
        hold(KNONE, 20);
        check("scan_a", int'(bus_if.operand_a), 7);

        // Bounce: first short burst must not register
        hold(4'd5, 3);
        hold(KNONE, 1);
        exp_keys.push_back(4'd5);
        hold(4'd5, 4);
        hold(KNONE, 20);
        check("bounce_a", int'(bus_if.operand_a), 75);
        press(4'hD);
        check_out("clr1", 0, 0, 0, 0, 0);

        // Digit limit, then E with no operator
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        check("a999", int'(bus_if.operand_a), 999);
        press(4'hE);
        check_out("e_in_a", 999, 0, 0, 0, 0);
        press(4'hD);

        // Operator overwrite, E without B digits, clear
        press(4'd2); press(4'hA); press(4'hC);
        check_out("op_mul", 2, 0, 2, 1, 0);
        press(4'hE);
        check_out("e_no_b", 2, 0, 2, 1, 0);
        press(4'hD);
        check_out("clr2", 0, 0, 0, 0, 0);

        // Async reset mid-press; no event afterwards
        hold(4'd3, 2);
        #2;
        reset  = 1'b1;
        sample = KNONE;
        #1;
        check("rstp_key_code",  int'(key_code), 15);
        check("rstp_key_valid", int'(key_valid), 0);
        check("rstp_state",     int'(entry_state), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hold(KNONE, 20);

        // Async reset while DONE
        press(4'd1); press(4'hC); press(4'd2); press(4'hE);
        check_out("done2", 1, 2, 2, 2, 1);
        #2;
        reset = 1'b1;
        #1;
        check_out("rstd", 0, 0, 0, 0, 0);
        check("rstd_key_code", int'(key_code), 15);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hold(KNONE, 20);

        check("keys_left", exp_keys.size(), 0);
        check("txns_left", exp_txn.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
